imem_access_ctrl: RTL

//  Sequences and shares the single-port instruction memory between two requesters: the

---
 rtl/imem_access_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/imem_access_ctrl.sv
// Shares a single-port instruction memory between the program loader (writes) and the
// fetch unit (reads) with round-robin arbitration and a registered read response.
module imem_access_ctrl #(
    parameter int DW    = 64,
    parameter int AW    = 64,
    parameter int DEPTH = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld_req_valid,
    output logic          ld_req_ready,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    output logic          ld_err,
    input  logic          fe_req_valid,
    output logic          fe_req_ready,
    input  logic [AW-1:0] fe_addr,
    output logic          fe_rsp_valid,
    input  logic          fe_rsp_ready,
    output logic [DW-1:0] fe_rsp_data,
    output logic          fe_rsp_err,
    output logic          mem_enable,
    output logic          mem_read,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_data_in,
    input  logic [DW-1:0] mem_data_out,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } state_e;

    localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

    state_e          state_q, state_d;
    logic            rr_q, rr_d;            // 1: fetch was granted last, loader wins next tie
    logic            rd_err_q, rd_err_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_data_q, rsp_data_d;
    logic            rsp_err_q, rsp_err_d;
    logic            ld_err_q, ld_err_d;
    logic            busy_q, busy_d;

    logic            grant_ld_s, grant_fe_s;
    logic            ld_in_range_s, fe_in_range_s;
    logic            mem_enable_s, mem_read_s;
    logic [AW-1:0]   mem_address_s;
    logic [DW-1:0]   mem_data_in_s;

    // Arbitration: grants only in IDLE, ties broken by the round-robin bit
    always_comb begin
        ld_in_range_s = (ld_addr < DEPTH_A);
        fe_in_range_s = (fe_addr < DEPTH_A);
        grant_ld_s    = 1'b0;
        grant_fe_s    = 1'b0;
        if (state_q == IDLE) begin
            grant_fe_s = fe_req_valid & (~ld_req_valid | ~rr_q);
            grant_ld_s = ld_req_valid & (~fe_req_valid | rr_q);
        end else begin
            grant_fe_s = 1'b0;
            grant_ld_s = 1'b0;
        end
    end

    // Memory port drive: an access is issued only for an in-range grant, else all zero
    always_comb begin
        mem_enable_s  = 1'b0;
        mem_read_s    = 1'b0;
        mem_address_s = {AW{1'b0}};
        mem_data_in_s = {DW{1'b0}};
        if (grant_ld_s && ld_in_range_s) begin
            mem_enable_s  = 1'b1;
            mem_read_s    = 1'b0;
            mem_address_s = ld_addr;
            mem_data_in_s = ld_data;
        end else if (grant_fe_s && fe_in_range_s) begin
            mem_enable_s  = 1'b1;
            mem_read_s    = 1'b1;
            mem_address_s = fe_addr;
        end else begin
            mem_enable_s  = 1'b0;
        end
    end

    // Next-state logic for the read sequencer and response register
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        rd_err_d    = rd_err_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        ld_err_d    = grant_ld_s & ~ld_in_range_s;
        case (state_q)
            IDLE: begin
                if (grant_fe_s) begin
                    state_d  = RD_WAIT;
                    rd_err_d = ~fe_in_range_s;
                    rr_d     = 1'b1;
                end else if (grant_ld_s) begin
                    rr_d     = 1'b0;
                end else begin
                    state_d  = IDLE;
                end
            end
            RD_WAIT: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = rd_err_q;
                rsp_data_d  = rd_err_q ? {DW{1'b0}} : mem_data_out;
                state_d     = RESP;
            end
            RESP: begin
                if (fe_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_data_d  = {DW{1'b0}};
                    rsp_err_d   = 1'b0;
                    rd_err_d    = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d     = RESP;
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
                rsp_data_d  = {DW{1'b0}};
                rsp_err_d   = 1'b0;
                rd_err_d    = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset discards any in-flight read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_q        <= 1'b0;
            rd_err_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= {DW{1'b0}};
            rsp_err_q   <= 1'b0;
            ld_err_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            rd_err_q    <= rd_err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            ld_err_q    <= ld_err_d;
            busy_q      <= busy_d;
        end
    end

    assign ld_req_ready = grant_ld_s;
    assign fe_req_ready = grant_fe_s;
    assign mem_enable   = mem_enable_s;
    assign mem_read     = mem_read_s;
    assign mem_address  = mem_address_s;
    assign mem_data_in  = mem_data_in_s;
    assign ld_err       = ld_err_q;
    assign fe_rsp_valid = rsp_valid_q;
    assign fe_rsp_data  = rsp_data_q;
    assign fe_rsp_err   = rsp_err_q;
    assign busy         = busy_q;

endmodule
